alu_seq_gen: RTL and testbench
==============================

# alu_seq_gen

Parametrised ALU test-program sequencer. It generates a Fibonacci-addition instruction stream of `NUM_REGS-1` entries and drives the register-file/ALU control bus: `regEnable`, `opcode`, `Rsrc`, `Rdest`, `imm`, `RorI`, `flagEn`. Compared with the fixed 16-state generator, this block adds:
- register count as a parameter;
- a start/busy/done handshake;
- multi-pass looping;
- stall back-pressure.

It sits between the board-level control (buttons/test harness) and the datapath.

## Interface
Parameters:
- `NUM_REGS`, 16, register-file size; power of two, ≥4; program length `PLEN = NUM_REGS-1`.
- `DATA_W`, 16, immediate width.
- `LOOP_W`, 8, width of pass count.

Derived:
- `REG_W = $clog2(NUM_REGS)`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin run; honoured only in IDLE or DONE.
- `loop_count`  in  LOOP_W  number of program passes, sampled on accepted `start`; 0 is treated as 1.
- `stall`  in  1  hold current entry; suppresses write.
- `regEnable`  out  NUM_REGS  one-hot write enable.
- `opcode`  out  8  ALU opcode.
- `Rsrc`, `Rdest`  out  REG_W  operand register indices.
- `imm`  out  DATA_W  immediate.
- `RorI`  out  1  1 = immediate operand.
- `flagEn`  out  1  flag update enable; always 0 in this program.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `pc`  out  REG_W  current entry index.
- `pass_idx`  out  LOOP_W  current pass, 0-based.

## Operation
States:
- IDLE: entered on reset.
- RUN:
  - `start` in IDLE or DONE → RUN, with `pc=0`, `pass_idx=0`, `passes` latched.
  - `start` while in RUN is ignored.
- Per RUN cycle:
  - `stall=1` → `pc` holds and `regEnable` is forced to 0; other outputs show the held entry.
  - `stall=0` at the entry `pc=PLEN-1`:
    - if `pass_idx+1 == passes` → DONE;
    - otherwise `pc=0`, `pass_idx++`, and the state stays RUN.
  - `stall=0` at any other entry → `pc++`.
- DONE: holds `done=1`, `pc`, and `pass_idx` until `start`.

Outputs are a combinational decode of (state, `pc`, `stall`). In IDLE and DONE they are NOP: `regEnable=0`, `opcode=8'h00`, `Rsrc=Rdest=0`, `imm=0`, `RorI=0`, `flagEn=0`.

Program contents:
- Entry 0: `ADDI` (`8'h50`), `Rdest=1`, `Rsrc=0`, `imm=1`, `RorI=1`, `regEnable[2]`.
- Entry k, 1 ≤ k ≤ NUM_REGS-3: `ADD` (`8'h05`), `Rdest=k+1`, `Rsrc=k`, `regEnable[k+2]`.
- Entry NUM_REGS-2: `MOV` (`8'h0D`), `Rsrc=NUM_REGS-1`, `Rdest=0`, `regEnable[NUM_REGS-1]`.
- `imm=0` and `RorI=0` for all entries except entry 0.
- `pass_idx` is at most `2^LOOP_W-1`; no wrap occurs, because the DONE compare uses the latched `passes`.

## Timing
- Reset values: `state=IDLE`, `pc=0`, `pass_idx=0`, `passes=1`, `busy=0`, `done=0`, all bus outputs NOP.
- `rst` asserted mid-run forces these values immediately, without waiting for `clk`.
- Latency: `start` sampled at edge e → entry 0 is on the bus in the cycle after e; one entry per non-stalled cycle.
- There is no bubble between passes.
- Run length in RUN cycles = `passes*PLEN + stall cycles`.
- `busy` falls and `done` rises at the edge following the last non-stalled entry.
- Simultaneous events:
  - `stall` on the last entry → hold; no DONE, no pass advance.
  - `start` together with `stall` in IDLE → start is accepted; `stall` only takes effect from the next cycle.
  - `start` in DONE → restart, with the new `loop_count` sampled.

## Configuration
- `ALU_SEQ_SINGLE_STEP_EN` defined:
  - adds port `step` (in, 1);
  - in RUN, an entry advances only on a cycle with `step=1 && stall=0`;
  - `regEnable` is non-zero only in those cycles; other outputs show the current entry.
- Macro undefined: no `step` port; an entry advances every non-stalled RUN cycle.

## Structure
- Shared package `alu_seq_pkg`:
  - opcode constants `OP_ADD`, `OP_ADDI`, `OP_MOV`, `OP_NOP`;
  - state enum `seq_state_t` (IDLE, RUN, DONE);
  - entry struct `seq_entry_t` (`we`, `wb_idx`, `opcode`, `rsrc`, `rdest`, `imm`, `rori`, `flagen`).
- Sub-module `alu_seq_rom`:
  - combinational `pc` → `seq_entry_t`, built by a generator function;
  - the top level decodes `wb_idx` into the one-hot `regEnable`.

## Test plan
- Reset then idle for 5 cycles → bus NOP, `busy=0`, `done=0`, `pc=0`.
- `start` with `loop_count=1`, NUM_REGS=16:
  - 15 RUN cycles;
  - cycle 0: `opcode=8'h50`, `imm=1`, `regEnable=16'h0004`;
  - cycle 13: `opcode=8'h05`, `Rdest=14`, `Rsrc=13`, `regEnable=16'h8000`;
  - cycle 14: `opcode=8'h0D`, `Rsrc=15`;
  - `done=1` on cycle 15.
- `loop_count=3` → 45 RUN cycles; `pass_idx` steps 0→1→2; `done` on cycle 45. With `loop_count=0` → 15 cycles.
- `stall` high 4 cycles at `pc=5`, then 2 cycles at `pc=14` → `regEnable=0` and `pc` held while stalled; `done` after 21 RUN cycles.
- `rst` at `pc=7` → outputs NOP and `busy=0` before the next edge. `start` during RUN at `pc=3` → ignored, `pc` continues to 4.
- With `ALU_SEQ_SINGLE_STEP_EN`: 3 `step` pulses separated by idle cycles → `pc` 0→3; `regEnable` asserted only in the step cycles.

Source files
------------

// File: rtl/alu_seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcodes, sequencer state type, program-entry record and
//               the generator function that defines the Fibonacci-addition
//               test program for alu_seq_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // ALU opcodes used by the generated program
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_MOV  = 8'h0D;
    localparam logic [7:0] OP_ADDI = 8'h50;

    // Entry fields are sized for the largest supported configuration
    // (NUM_REGS <= 256, DATA_W <= 32); the top level slices them down.
    localparam int IDX_W = 8;
    localparam int IMM_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic             we;
        logic [IDX_W-1:0] wb_idx;
        logic [7:0]       opcode;
        logic [IDX_W-1:0] rsrc;
        logic [IDX_W-1:0] rdest;
        logic [IMM_W-1:0] imm;
        logic             rori;
        logic             flagen;
    } seq_entry_t;

    // Program entry for index idx of a NUM_REGS-register program
    function automatic seq_entry_t seq_entry_gen(input int unsigned idx,
                                                 input int unsigned num_regs);
        seq_entry_t e;
        e        = '0;
        e.opcode = OP_NOP;
        if (idx == 0) begin
            e.we     = 1'b1;
            e.wb_idx = IDX_W'(2);
            e.opcode = OP_ADDI;
            e.rdest  = IDX_W'(1);
            e.rsrc   = '0;
            e.imm    = IMM_W'(1);
            e.rori   = 1'b1;
        end else if (idx <= num_regs - 3) begin
            e.we     = 1'b1;
            e.wb_idx = IDX_W'(idx + 2);
            e.opcode = OP_ADD;
            e.rdest  = IDX_W'(idx + 1);
            e.rsrc   = IDX_W'(idx);
        end else if (idx == num_regs - 2) begin
            e.we     = 1'b1;
            e.wb_idx = IDX_W'(num_regs - 1);
            e.opcode = OP_MOV;
            e.rdest  = '0;
            e.rsrc   = IDX_W'(num_regs - 1);
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_gen_if
// Description : Control handshake and register-file/ALU bus of alu_seq_gen.
//               master = board control / harness, slave = the sequencer.
//               Optional macro ALU_SEQ_SINGLE_STEP_EN adds the step input.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_gen_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int LOOP_W   = 8
) ();
    localparam int REG_W = $clog2(NUM_REGS);

    logic              start;
    logic [LOOP_W-1:0] loop_count;
    logic              stall;
`ifdef ALU_SEQ_SINGLE_STEP_EN
    logic              step;
`endif
    logic [NUM_REGS-1:0] regEnable;
    logic [7:0]          opcode;
    logic [REG_W-1:0]    Rsrc;
    logic [REG_W-1:0]    Rdest;
    logic [DATA_W-1:0]   imm;
    logic                RorI;
    logic                flagEn;
    logic                busy;
    logic                done;
    logic [REG_W-1:0]    pc;
    logic [LOOP_W-1:0]   pass_idx;

`ifdef ALU_SEQ_SINGLE_STEP_EN
    modport master (output start, loop_count, stall, step,
                    input  regEnable, opcode, Rsrc, Rdest, imm, RorI, flagEn,
                           busy, done, pc, pass_idx);
    modport slave  (input  start, loop_count, stall, step,
                    output regEnable, opcode, Rsrc, Rdest, imm, RorI, flagEn,
                           busy, done, pc, pass_idx);
`else
    modport master (output start, loop_count, stall,
                    input  regEnable, opcode, Rsrc, Rdest, imm, RorI, flagEn,
                           busy, done, pc, pass_idx);
    modport slave  (input  start, loop_count, stall,
                    output regEnable, opcode, Rsrc, Rdest, imm, RorI, flagEn,
                           busy, done, pc, pass_idx);
`endif
endinterface
`default_nettype wire

// File: rtl/alu_seq_gen_rom.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_rom
// Description : Combinational program store: maps pc to its program entry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_rom
    import alu_seq_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    localparam int REG_W    = $clog2(NUM_REGS)
) (
    input  logic [REG_W-1:0] pc,
    output seq_entry_t       entry
);

    // Table lookup through the shared generator function
    always_comb begin
        entry = seq_entry_gen(32'(pc), NUM_REGS);
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_gen
// Description : ALU test-program sequencer. Streams a NUM_REGS-1 entry
//               Fibonacci-addition program onto the register-file/ALU bus,
//               with start/busy/done handshake, multi-pass looping and stall.
//               Optional macro ALU_SEQ_SINGLE_STEP_EN: entries advance only
//               on cycles with step=1 (and stall=0).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_gen
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int LOOP_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_gen_if.slave  bus
);
    localparam int               REG_W     = $clog2(NUM_REGS);
    localparam logic [REG_W-1:0] c_last_pc = REG_W'(NUM_REGS - 2);

    seq_state_t        r_state, w_state_nxt;
    logic [REG_W-1:0]  r_pc, w_pc_nxt;
    logic [LOOP_W-1:0] r_pass_idx, w_pass_nxt;
    logic [LOOP_W-1:0] r_passes, w_passes_nxt;
    logic              w_adv;
    seq_entry_t        w_entry;
    logic              w_unused;

    // An entry is consumed (and written back) only on an advancing RUN cycle
`ifdef ALU_SEQ_SINGLE_STEP_EN
    assign w_adv = (r_state == RUN) && !bus.stall && bus.step;
`else
    assign w_adv = (r_state == RUN) && !bus.stall;
`endif

    alu_seq_rom #(.NUM_REGS(NUM_REGS)) u_rom (
        .pc    (r_pc),
        .entry (w_entry)
    );

    // Entry fields are wider than this configuration needs
    assign w_unused = ^{w_entry.wb_idx, w_entry.rsrc, w_entry.rdest, w_entry.imm};

    // State, program counter and pass bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_pass_idx <= '0;
            r_passes   <= LOOP_W'(1);
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pass_idx <= w_pass_nxt;
            r_passes   <= w_passes_nxt;
        end
    end

    // Next-state: start from IDLE/DONE, advance/wrap/finish in RUN
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pass_nxt   = r_pass_idx;
        w_passes_nxt = r_passes;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt  = RUN;
                    w_pc_nxt     = '0;
                    w_pass_nxt   = '0;
                    w_passes_nxt = (bus.loop_count == '0) ? LOOP_W'(1) : bus.loop_count;
                end
            end
            RUN: begin
                if (w_adv) begin
                    if (r_pc == c_last_pc) begin
                        // passes is never 0, so passes-1 cannot underflow
                        if (r_pass_idx == (r_passes - LOOP_W'(1))) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_pc_nxt   = '0;
                            w_pass_nxt = r_pass_idx + LOOP_W'(1);
                        end
                    end else begin
                        w_pc_nxt = r_pc + REG_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus decode: current entry while running, NOP otherwise
    always_comb begin
        bus.regEnable = '0;
        bus.opcode    = OP_NOP;
        bus.Rsrc      = '0;
        bus.Rdest     = '0;
        bus.imm       = '0;
        bus.RorI      = 1'b0;
        bus.flagEn    = 1'b0;
        if (r_state == RUN) begin
            bus.opcode = w_entry.opcode;
            bus.Rsrc   = w_entry.rsrc[REG_W-1:0];
            bus.Rdest  = w_entry.rdest[REG_W-1:0];
            bus.imm    = w_entry.imm[DATA_W-1:0];
            bus.RorI   = w_entry.rori;
            bus.flagEn = w_entry.flagen;
            if (w_adv && w_entry.we) begin
                bus.regEnable = NUM_REGS'(1) << w_entry.wb_idx[REG_W-1:0];
            end
        end
    end

    assign bus.busy     = (r_state == RUN);
    assign bus.done     = (r_state == DONE);
    assign bus.pc       = r_pc;
    assign bus.pass_idx = r_pass_idx;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_gen
// Description : Self-checking bench for alu_seq_gen (NUM_REGS=16). Reference
//               model tracks the number of completed entries; pc and pass are
//               derived from it. Honours ALU_SEQ_SINGLE_STEP_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_gen;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;
    localparam int LOOP_W   = 8;
    localparam int PLEN     = NUM_REGS - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_gen_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .LOOP_W(LOOP_W)) bus ();

    alu_seq_gen #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .LOOP_W(LOOP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected program, from the instruction-stream rules
    int e_op[PLEN], e_src[PLEN], e_dst[PLEN], e_imm[PLEN], e_rori[PLEN], e_wb[PLEN];

    // Reference model: mode 0 idle, 1 run, 2 done; m_cnt = entries completed
    int m_mode = 0, m_cnt = 0, m_passes = 1;

    // Stimulus
    logic       d_start = 1'b0, d_stall = 1'b0, d_rst = 1'b1, d_step = 1'b1;
    logic [7:0] d_lc = 8'd1;

    // Snapshot of DUT outputs at the last compare point
    logic [63:0] s_re, s_op, s_pc, s_pass, s_src, s_dst, s_imm;
    logic        s_busy, s_done;

    typedef struct {
        logic [7:0] lc;
        int         st_pc;
        int         st_len;
        int         exp_cycles;
    } run_case_t;
    run_case_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_mode = 0; m_cnt = 0; m_passes = 1;
    endtask

    task automatic mdl_step();
        if (m_mode != 1) begin
            if (d_start) begin
                m_mode   = 1;
                m_cnt    = 0;
                m_passes = (d_lc == 0) ? 1 : int'(d_lc);
            end
        end else if (!d_stall && d_step) begin
            m_cnt++;
            if (m_cnt == m_passes * PLEN) m_mode = 2;
        end
    endtask

    task automatic compare_all();
        int idx;
        logic [63:0] x_pc, x_pass, x_re, x_op, x_src, x_dst, x_imm, x_rori;
        x_pc = 0; x_pass = 0; x_re = 0; x_op = 0; x_src = 0; x_dst = 0; x_imm = 0; x_rori = 0;
        if (m_mode == 1) begin
            idx    = m_cnt % PLEN;
            x_pc   = 64'(idx);
            x_pass = 64'(m_cnt / PLEN);
            x_op   = 64'(e_op[idx]);
            x_src  = 64'(e_src[idx]);
            x_dst  = 64'(e_dst[idx]);
            x_imm  = 64'(e_imm[idx]);
            x_rori = 64'(e_rori[idx]);
            x_re   = (!d_stall && d_step) ? (64'd1 << e_wb[idx]) : 64'd0;
        end else if (m_mode == 2) begin
            x_pc   = 64'(PLEN - 1);
            x_pass = 64'(m_passes - 1);
        end
        chk("busy",      64'(bus.busy),      64'(m_mode == 1));
        chk("done",      64'(bus.done),      64'(m_mode == 2));
        chk("pc",        64'(bus.pc),        x_pc);
        chk("pass_idx",  64'(bus.pass_idx),  x_pass);
        chk("regEnable", 64'(bus.regEnable), x_re);
        chk("opcode",    64'(bus.opcode),    x_op);
        chk("Rsrc",      64'(bus.Rsrc),      x_src);
        chk("Rdest",     64'(bus.Rdest),     x_dst);
        chk("imm",       64'(bus.imm),       x_imm);
        chk("RorI",      64'(bus.RorI),      x_rori);
        chk("flagEn",    64'(bus.flagEn),    64'd0);
        s_re = 64'(bus.regEnable); s_op = 64'(bus.opcode); s_pc = 64'(bus.pc);
        s_pass = 64'(bus.pass_idx); s_src = 64'(bus.Rsrc); s_dst = 64'(bus.Rdest);
        s_imm = 64'(bus.imm); s_busy = bus.busy; s_done = bus.done;
    endtask

    // One clock: drive at negedge, compare, then let the edge happen
    task automatic cycle();
        @(negedge clk);
        bus.start      = d_start;
        bus.stall      = d_stall;
        bus.loop_count = d_lc;
`ifdef ALU_SEQ_SINGLE_STEP_EN
        bus.step       = d_step;
`endif
        rst            = d_rst;
        if (d_rst) mdl_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        if (!d_rst) mdl_step();
    endtask

    task automatic run_case(input run_case_t rc, input int num);
        int n, stalled;
        string nm;
        nm = $sformatf("case%0d", num);
        d_lc = rc.lc; d_start = 1'b1; d_stall = 1'b0;
        cycle();
        d_start = 1'b0;
        n = 0; stalled = 0;
        while (bus.busy === 1'b1 && n < 600) begin
            d_stall = (m_mode == 1) && ((m_cnt % PLEN) == rc.st_pc) && (stalled < rc.st_len);
            if (d_stall) stalled++;
            cycle();
            n++;
        end
        d_stall = 1'b0;
        chk({nm, " run cycles"}, 64'(n), 64'(rc.exp_cycles));
        chk({nm, " done"}, 64'(bus.done), 64'd1);
    endtask

    initial begin
        int n, s5, s14;
        bus.start = 1'b0; bus.stall = 1'b0; bus.loop_count = 8'd1;
`ifdef ALU_SEQ_SINGLE_STEP_EN
        bus.step = 1'b1;
`endif
        for (int k = 0; k < PLEN; k++) begin
            e_imm[k] = 0; e_rori[k] = 0;
            if (k == 0) begin
                e_op[k] = 'h50; e_dst[k] = 1; e_src[k] = 0; e_imm[k] = 1; e_rori[k] = 1; e_wb[k] = 2;
            end else if (k <= NUM_REGS - 3) begin
                e_op[k] = 'h05; e_dst[k] = k + 1; e_src[k] = k; e_wb[k] = k + 2;
            end else begin
                e_op[k] = 'h0D; e_dst[k] = 0; e_src[k] = NUM_REGS - 1; e_wb[k] = NUM_REGS - 1;
            end
        end
        tbl[0] = '{lc: 8'd1, st_pc: -1, st_len: 0, exp_cycles: 15};
        tbl[1] = '{lc: 8'd3, st_pc: -1, st_len: 0, exp_cycles: 45};
        tbl[2] = '{lc: 8'd0, st_pc: -1, st_len: 0, exp_cycles: 15};
        tbl[3] = '{lc: 8'd1, st_pc: 5,  st_len: 4, exp_cycles: 19};
        tbl[4] = '{lc: 8'd2, st_pc: 14, st_len: 3, exp_cycles: 33};

        // Reset, then idle
        d_rst = 1'b1; cycle(); cycle();
        d_rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("idle busy", 64'(s_busy), 64'd0);
        chk("idle done", 64'(s_done), 64'd0);
        chk("idle pc", s_pc, 64'd0);
        chk("idle regEnable", s_re, 64'd0);
        chk("idle opcode", s_op, 64'd0);

        // Single pass; start presented together with stall in IDLE
        d_lc = 8'd1; d_start = 1'b1; d_stall = 1'b1; cycle();
        d_start = 1'b0; d_stall = 1'b0;
        chk("start with stall accepted", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (i == 0) begin
                chk("c0 opcode", s_op, 64'h50); chk("c0 imm", s_imm, 64'd1);
                chk("c0 regEnable", s_re, 64'h0004);
            end
            if (i == 13) begin
                chk("c13 opcode", s_op, 64'h05); chk("c13 Rdest", s_dst, 64'd14);
                chk("c13 Rsrc", s_src, 64'd13); chk("c13 regEnable", s_re, 64'h8000);
            end
            if (i == 14) begin
                chk("c14 opcode", s_op, 64'h0D); chk("c14 Rsrc", s_src, 64'd15);
            end
        end
        chk("single pass done", 64'(bus.done), 64'd1);
        chk("single pass busy", 64'(bus.busy), 64'd0);

        // Table of run-length cases (each restarts from DONE)
        for (int t = 0; t < 5; t++) run_case(tbl[t], t);

        // Three passes: pass_idx stepping
        d_lc = 8'd3; d_start = 1'b1; cycle(); d_start = 1'b0;
        for (int i = 0; i < 45; i++) begin
            cycle();
            if (i == 0)  chk("pass0", s_pass, 64'd0);
            if (i == 15) chk("pass1", s_pass, 64'd1);
            if (i == 30) chk("pass2", s_pass, 64'd2);
            if (i == 44) chk("last entry pc", s_pc, 64'd14);
        end
        chk("3-pass done", 64'(bus.done), 64'd1);

        // Stall 4 cycles at pc=5 and 2 cycles at pc=14
        d_lc = 8'd1; d_start = 1'b1; cycle(); d_start = 1'b0;
        n = 0; s5 = 0; s14 = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            d_stall = ((m_cnt % PLEN) == 5 && s5 < 4) || ((m_cnt % PLEN) == 14 && s14 < 2);
            if (d_stall && (m_cnt % PLEN) == 5) s5++;
            if (d_stall && (m_cnt % PLEN) == 14) s14++;
            cycle();
            if (d_stall) chk("stalled regEnable", s_re, 64'd0);
            n++;
        end
        d_stall = 1'b0;
        chk("stalled run cycles", 64'(n), 64'd21);
        chk("stalled run done", 64'(bus.done), 64'd1);

        // start during RUN is ignored; then asynchronous reset at pc=7
        d_start = 1'b1; cycle(); d_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        d_start = 1'b1; cycle(); d_start = 1'b0;
        chk("start in RUN pc", s_pc, 64'd3);
        cycle();
        chk("after ignored start pc", s_pc, 64'd4);
        cycle(); cycle();
        chk("pre-reset pc", 64'(bus.pc), 64'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst busy", 64'(bus.busy), 64'd0);
        chk("async rst regEnable", 64'(bus.regEnable), 64'd0);
        chk("async rst opcode", 64'(bus.opcode), 64'd0);
        chk("async rst pc", 64'(bus.pc), 64'd0);
        mdl_reset();
        @(posedge clk); #1;
        cycle();

`ifdef ALU_SEQ_SINGLE_STEP_EN
        // Single-step: three step pulses separated by idle cycles
        d_lc = 8'd1; d_start = 1'b1; cycle(); d_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d_step = (i % 3 == 1);
            cycle();
            chk("step regEnable", 64'(s_re != 0), 64'(d_step));
        end
        d_step = 1'b1;
        chk("step pc", 64'(bus.pc), 64'd3);
`endif

        // Random stimulus against the model
        for (int i = 0; i < 2500; i++) begin
            d_rst   = ($urandom % 400) == 0;
            d_start = ($urandom % 16) == 0;
            d_stall = ($urandom % 4) == 0;
            d_lc    = 8'($urandom % 4);
`ifdef ALU_SEQ_SINGLE_STEP_EN
            d_step  = ($urandom % 4) != 0;
`endif
            cycle();
        end
        d_rst = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
